// File: rtl/reg_file_16x16_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_16x16_pkg
//   Shared constants for the Group 9 register file and the operand muxes that
//   read it.
//   - REG_W / NUM_REGS must stay identical to the values the 16:1 operand
//     muxes are built with.
//   - BE_* name the byte-enable patterns for the low byte, the high byte and
//     the whole word.
//   - onehot16() turns a qualified 4-bit register index into a 16-bit
//     one-hot select vector.
// ----------------------------------------------------------------------------
package reg_file_16x16_pkg;

  localparam int REG_W    = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  // One-hot decode of a register index.
  // A deasserted enable gives an all-zero vector.
  function automatic logic [NUM_REGS-1:0] onehot16(input logic en,
                                                   input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = {NUM_REGS{1'b0}};
    if (en) begin
      sel[idx] = 1'b1;
    end else begin
      sel = {NUM_REGS{1'b0}};
    end
    return sel;
  endfunction

endpackage : reg_file_16x16_pkg

// File: rtl/reg_file_16x16_reg16_be.sv
// ----------------------------------------------------------------------------
// reg16_be
//   A single 16-bit register with two byte lanes.
//   Ports:
//     clk_i    rising-edge clock
//     rst_ni   asynchronous active-low reset; loads RESET_VAL
//     we_i     write enable
//     be_i     byte enables: bit0 -> [7:0], bit1 -> [15:8]
//     d_i      write data
//     q_o      registered contents
//   A lane whose enable is low keeps its previous value, even while we_i is
//   high.
// ----------------------------------------------------------------------------
module reg16_be
  import reg_file_16x16_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [1:0]       be_i,
  input  logic [REG_W-1:0] d_i,
  output logic [REG_W-1:0] q_o
);

  logic [REG_W-1:0] q_q;
  logic [REG_W-1:0] q_d;

  // Next-state merge: replace only the enabled byte lanes.
  always_comb begin
    q_d = q_q;
    if (we_i) begin
      if ((be_i & BE_LO) != 2'b00) begin
        q_d[7:0] = d_i[7:0];
      end else begin
        q_d[7:0] = q_q[7:0];
      end
      if ((be_i & BE_HI) != 2'b00) begin
        q_d[15:8] = d_i[15:8];
      end else begin
        q_d[15:8] = q_q[15:8];
      end
    end else begin
      q_d = q_q;
    end
  end

  // Storage register with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : reg16_be

// File: rtl/reg_file_16x16.sv
// ----------------------------------------------------------------------------
// reg_file_16x16
//   A 16 x 16-bit general-purpose register file with a per-register busy
//   scoreboard.
//   Ports:
//     clk, reset_n           clock; asynchronous active-low reset
//     wr_en/wr_addr/wr_data/wr_be
//                            one writeback per cycle, with byte enables
//     lock_en/lock_addr      marks a register busy when a multi-cycle load is
//                            issued
//     rd_chk_a/rd_chk_b      source indices that feed the hazard check
//     r0..r15                registered contents for the operand muxes
//     busy                   scoreboard; bit n = write pending on rn
//     hazard                 combinational: busy[rd_chk_a] | busy[rd_chk_b]
//     lock_err               one-cycle pulse when a lock hits a busy register
//   Write data appears on rn the cycle after the edge. There is no read bypass
//   here; same-cycle forwarding is handled downstream.
//   DATA_W must remain 16, because the byte lanes are fixed at two.
// ----------------------------------------------------------------------------
module reg_file_16x16
  import reg_file_16x16_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [1:0]          wr_be,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic [ADDR_W-1:0]   rd_chk_a,
  input  logic [ADDR_W-1:0]   rd_chk_b,
  output logic [DATA_W-1:0]   r0,
  output logic [DATA_W-1:0]   r1,
  output logic [DATA_W-1:0]   r2,
  output logic [DATA_W-1:0]   r3,
  output logic [DATA_W-1:0]   r4,
  output logic [DATA_W-1:0]   r5,
  output logic [DATA_W-1:0]   r6,
  output logic [DATA_W-1:0]   r7,
  output logic [DATA_W-1:0]   r8,
  output logic [DATA_W-1:0]   r9,
  output logic [DATA_W-1:0]   r10,
  output logic [DATA_W-1:0]   r11,
  output logic [DATA_W-1:0]   r12,
  output logic [DATA_W-1:0]   r13,
  output logic [DATA_W-1:0]   r14,
  output logic [DATA_W-1:0]   r15,
  output logic [NUM_REGS-1:0] busy,
  output logic                hazard,
  output logic                lock_err
);

  logic [NUM_REGS-1:0] wr_sel_s;
  logic [NUM_REGS-1:0] lock_sel_s;
  logic [DATA_W-1:0]   regs_s [NUM_REGS];

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                lock_err_q;
  logic                lock_err_d;

  // Address decode for the writeback port and the lock port.
  always_comb begin
    wr_sel_s   = onehot16(wr_en, wr_addr);
    lock_sel_s = onehot16(lock_en, lock_addr);
  end

  // One byte-lane register per architectural register. r0 is an ordinary
  // register.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    reg16_be #(
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .we_i   (wr_sel_s[g]),
      .be_i   (wr_be),
      .d_i    (wr_data),
      .q_o    (regs_s[g])
    );
  end

  // Scoreboard and lock-error next state.
  // A write clears its bit and a lock sets it. The set is ORed in after the
  // clear, so a lock and a write to the same register leave it busy: the new
  // load is still outstanding. A lock that coincides with the completing write
  // of the same register is therefore not an error.
  always_comb begin
    busy_d     = (busy_q & ~wr_sel_s) | lock_sel_s;
    lock_err_d = 1'b0;
    if (lock_en) begin
      lock_err_d = busy_q[lock_addr] & ~wr_sel_s[lock_addr];
    end else begin
      lock_err_d = 1'b0;
    end
  end

  // Scoreboard and error-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= {NUM_REGS{1'b0}};
      lock_err_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      lock_err_q <= lock_err_d;
    end
  end

  // The hazard check uses the current busy bits only. A write in this cycle
  // clears its bit after the edge.
  assign hazard   = busy_q[rd_chk_a] | busy_q[rd_chk_b];
  assign busy     = busy_q;
  assign lock_err = lock_err_q;

  assign r0  = regs_s[0];
  assign r1  = regs_s[1];
  assign r2  = regs_s[2];
  assign r3  = regs_s[3];
  assign r4  = regs_s[4];
  assign r5  = regs_s[5];
  assign r6  = regs_s[6];
  assign r7  = regs_s[7];
  assign r8  = regs_s[8];
  assign r9  = regs_s[9];
  assign r10 = regs_s[10];
  assign r11 = regs_s[11];
  assign r12 = regs_s[12];
  assign r13 = regs_s[13];
  assign r14 = regs_s[14];
  assign r15 = regs_s[15];

endmodule : reg_file_16x16

// File: tb/tb_reg_file_16x16.sv
// ----------------------------------------------------------------------------
// tb_reg_file_16x16
//   Self-checking bench for reg_file_16x16.
//   - A directed vector table supplies explicit expected values.
//   - Hand-written sequences cover asynchronous reset.
//   - A randomized phase is checked against an array-based reference model.
// ----------------------------------------------------------------------------
module tb_reg_file_16x16;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        lock_en;
  logic [3:0]  lock_addr;
  logic [3:0]  rd_chk_a;
  logic [3:0]  rd_chk_b;
  logic [15:0] r_s [16];
  logic [15:0] busy;
  logic        hazard;
  logic        lock_err;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [15:0] m_regs [16];
  logic [15:0] m_busy;
  logic        m_lerr;

  reg_file_16x16 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .rd_chk_a  (rd_chk_a),
    .rd_chk_b  (rd_chk_b),
    .r0  (r_s[0]),  .r1  (r_s[1]),  .r2  (r_s[2]),  .r3  (r_s[3]),
    .r4  (r_s[4]),  .r5  (r_s[5]),  .r6  (r_s[6]),  .r7  (r_s[7]),
    .r8  (r_s[8]),  .r9  (r_s[9]),  .r10 (r_s[10]), .r11 (r_s[11]),
    .r12 (r_s[12]), .r13 (r_s[13]), .r14 (r_s[14]), .r15 (r_s[15]),
    .busy      (busy),
    .hazard    (hazard),
    .lock_err  (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        lock_en;
    logic [3:0]  lock_addr;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic [3:0]  chk_addr;
    logic [15:0] exp_reg;
    logic [15:0] exp_busy;
    logic        exp_lerr;
    logic        exp_haz;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_busy = 16'h0000;
    m_lerr = 1'b0;
  endtask

  // Reference model of one clock edge, built from the writeback and scoreboard
  // rules.
  task automatic model_step();
    logic        wr_same;
    logic [15:0] mask;
    wr_same = wr_en && (wr_addr == lock_addr);
    m_lerr  = lock_en && m_busy[lock_addr] && !wr_same;
    if (wr_en) begin
      mask = {{8{wr_be[1]}}, {8{wr_be[0]}}};
      m_regs[wr_addr] = (m_regs[wr_addr] & ~mask) | (wr_data & mask);
      m_busy[wr_addr] = 1'b0;
    end
    if (lock_en) m_busy[lock_addr] = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_r%0d", tag, i), {16'h0, r_s[i]}, {16'h0, m_regs[i]});
    chk({tag, "_busy"}, {16'h0, busy}, {16'h0, m_busy});
    chk({tag, "_lock_err"}, {31'h0, lock_err}, {31'h0, m_lerr});
    chk({tag, "_hazard"}, {31'h0, hazard},
        {31'h0, (m_busy[rd_chk_a] | m_busy[rd_chk_b])});
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then sample
  // 1 time unit later.
  task automatic cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic le, input logic [3:0] la,
                       input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    lock_en = le; lock_addr = la; rd_chk_a = ra; rd_chk_b = rb;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000; wr_be = 2'b00;
    lock_en = 1'b0; lock_addr = 4'd0; rd_chk_a = 4'd0; rd_chk_b = 4'd0;
  endtask

  initial begin
    // wr_en, wa, wd, be, lock_en, la, ra, rb, chk_addr, exp_reg, exp_busy, lerr, haz
    tbl[0]  = '{1'b1, 4'd5,  16'hBEEF, 2'b11, 1'b0, 4'd0,  4'd0,  4'd0, 4'd5,  16'hBEEF, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd3,  16'h1234, 2'b11, 1'b0, 4'd0,  4'd0,  4'd0, 4'd3,  16'h1234, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd3,  16'hABCD, 2'b01, 1'b0, 4'd0,  4'd0,  4'd0, 4'd3,  16'h12CD, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd3,  16'hABCD, 2'b10, 1'b0, 4'd0,  4'd0,  4'd0, 4'd3,  16'hABCD, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd3,  16'h0000, 2'b00, 1'b0, 4'd0,  4'd0,  4'd0, 4'd3,  16'hABCD, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd7,  4'd7,  4'd0, 4'd7,  16'h0000, 16'h0080, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 4'd7,  16'h0042, 2'b11, 1'b0, 4'd0,  4'd7,  4'd0, 4'd7,  16'h0042, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd9,  4'd0,  4'd0, 4'd9,  16'h0000, 16'h0200, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'd9,  16'h5555, 2'b11, 1'b1, 4'd9,  4'd9,  4'd0, 4'd9,  16'h5555, 16'h0200, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd9,  4'd0,  4'd9, 4'd9,  16'h5555, 16'h0200, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b0, 4'd0,  4'd0,  4'd0, 4'd9,  16'h5555, 16'h0200, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'd9,  16'h0001, 2'b01, 1'b0, 4'd0,  4'd9,  4'd0, 4'd9,  16'h5501, 16'h0000, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'd0,  16'hFFFF, 2'b11, 1'b1, 4'd15, 4'd15, 4'd0, 4'd0,  16'hFFFF, 16'h8000, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 4'd15, 16'h1111, 2'b11, 1'b0, 4'd0,  4'd0, 4'd15, 4'd15, 16'h1111, 16'h0000, 1'b0, 1'b0};

    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_model("reset");

    // Directed table.
    for (int v = 0; v < 14; v++) begin
      cycle(tbl[v].wr_en, tbl[v].wr_addr, tbl[v].wr_data, tbl[v].wr_be,
            tbl[v].lock_en, tbl[v].lock_addr, tbl[v].rd_a, tbl[v].rd_b);
      chk($sformatf("vec%0d_reg", v), {16'h0, r_s[tbl[v].chk_addr]}, {16'h0, tbl[v].exp_reg});
      chk($sformatf("vec%0d_busy", v), {16'h0, busy}, {16'h0, tbl[v].exp_busy});
      chk($sformatf("vec%0d_lock_err", v), {31'h0, lock_err}, {31'h0, tbl[v].exp_lerr});
      chk($sformatf("vec%0d_hazard", v), {31'h0, hazard}, {31'h0, tbl[v].exp_haz});
      chk_model($sformatf("vec%0d_model", v));
    end

    // Asynchronous reset while lock_err is high. No clock edge occurs before
    // the check.
    cycle(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2, 4'd2, 4'd0);
    cycle(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2, 4'd2, 4'd0);
    chk("pre_reset_lock_err", {31'h0, lock_err}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk_model("async_reset");
    #1 reset_n = 1'b1;

    // Reset during a pending write while busy = 16'h00F0.
    cycle(1'b1, 4'd4, 16'h4321, 2'b11, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 4; i < 8; i++) cycle(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, i[3:0], 4'd4, 4'd0);
    chk("busy_f0", {16'h0, busy}, 32'h0000_00F0);
    chk("r4_before", {16'h0, r_s[4]}, 32'h0000_4321);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h7777; wr_be = 2'b11; lock_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("midop_r4", {16'h0, r_s[4]}, 32'h0);
    chk("midop_busy", {16'h0, busy}, 32'h0);
    idle_inputs();
    #1 reset_n = 1'b1;
    model_reset();
    cycle(1'b1, 4'd4, 16'h7777, 2'b11, 1'b0, 4'd0, 4'd4, 4'd0);
    chk("post_reset_r4", {16'h0, r_s[4]}, 32'h0000_7777);
    chk_model("post_reset");

    // Randomized traffic, checked against the reference model.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file_16x16

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry x 16-bit general-purpose register file for the Group 9 datapath.
- Directly upstream of the 16:1 operand multiplexers.
- Presents every register continuously on r0..r15, which the A and B operand muxes select from.
- Accepts one writeback per cycle with byte enables.
- Keeps a per-register busy scoreboard so control can stall on registers whose multi-cycle load has not yet returned.

Parameters:
- DATA_W, 16, register width in bits; must be 16 because byte lanes are fixed at two.
- RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  writeback strobe; samples wr_addr, wr_data and wr_be.
- wr_addr  input  4  destination register index.
- wr_data  input  16  writeback data.
- wr_be  input  2  byte enables; bit0 = [7:0], bit1 = [15:8].
- lock_en  input  1  marks lock_addr as busy because a load has been issued.
- lock_addr  input  4  register to mark busy.
- rd_chk_a  input  4  source index A for the hazard check.
- rd_chk_b  input  4  source index B for the hazard check.
- r0..r15  output  16 each  registered contents, feeding the operand muxes.
- busy  output  16  scoreboard; bit n = 1 means rn has a write pending.
- hazard  output  1  combinational; busy[rd_chk_a] | busy[rd_chk_b].
- lock_err  output  1  one-cycle registered pulse when a lock targets an already-busy register.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - all r0..r15 = RESET_VAL;
  - busy = 16'h0000;
  - lock_err = 0.
  - Reset takes effect immediately, mid-write or mid-lock included. No write or lock in flight survives.
- Write, on clk rising edge with wr_en = 1:
  - rn[7:0] <= wr_data[7:0] if wr_be[0];
  - rn[15:8] <= wr_data[15:8] if wr_be[1];
  - unselected bytes hold;
  - wr_be = 2'b00 writes no data but still counts as a write for scoreboard clearing.
- Write latency: new data is visible on rn the cycle after the edge. There is no internal read-during-write bypass; a same-cycle bypass is the forwarding logic's job.
- No register is hardwired; r0 is writable like all others.
- Scoreboard, next-state per bit n:
  - busy[n]_next = (busy[n] & ~(wr_en & wr_addr == n)) | (lock_en & lock_addr == n).
  - Simultaneous write and lock to the same n: busy ends at 1. The old load returns while a new one is issued, so lock wins.
  - Simultaneous write and lock to different registers: both take effect independently.
- lock_err:
  - Next value = lock_en & busy[lock_addr] & ~(wr_en & wr_addr == lock_addr).
  - Locking a register whose pending write completes in the same cycle is not an error.
  - Busy stays 1 after an error; there is no counting, so one write clears it.
- hazard:
  - Purely combinational from the current busy and the rd_chk indices.
  - Does not see a same-cycle write; it clears the cycle after the write edge.
- Writing a non-busy register is legal and leaves busy unchanged.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package/include: REG_W = 16, NUM_REGS = 16, BE_LO = 2'b01, BE_HI = 2'b10, BE_WORD = 2'b11.
- Keep REG_W and NUM_REGS as the same constants the operand mux uses.
- One natural sub-module, reg16_be: a single 16-bit register with async active-low reset, write enable and byte enables, instantiated 16 times.
- The address decode, scoreboard and lock_err logic stay in the top level.

Test Plan:
- Reset / basic write:
  - Assert reset_n = 0 mid-run -> r0..r15 = 16'h0000, busy = 0, lock_err = 0 without waiting for a clk edge.
  - Release reset, then wr_en = 1, wr_addr = 5, wr_data = 16'hBEEF, wr_be = 2'b11 -> r5 = 16'hBEEF next cycle; all other registers stay 0.
- Byte lanes:
  - With r3 = 16'h1234, write 16'hABCD with wr_be = 2'b01 -> r3 = 16'h12CD.
  - Then the same data with wr_be = 2'b10 -> r3 = 16'hABCD.
  - Then wr_be = 2'b00 -> r3 unchanged.
- Scoreboard:
  - lock_en = 1, lock_addr = 7 -> busy = 16'h0080.
  - rd_chk_a = 7 -> hazard = 1.
  - Write r7 = 16'h0042 -> next cycle busy = 0, hazard = 0, r7 = 16'h0042.
- Simultaneous events:
  - With busy[9] = 1, write r9 and lock r9 in the same cycle -> busy[9] stays 1, lock_err = 0, r9 updated.
  - Lock r9 again with no write -> lock_err pulses 1 for exactly one cycle.
- Independent updates:
  - Write r0 = 16'hFFFF while locking r15 in the same cycle -> r0 = 16'hFFFF, busy = 16'h8000.
  - Also confirm that r0 is not hardwired.
- Reset mid-operation:
  - With busy = 16'h00F0 and a write to r4 in progress, pulse reset_n low between edges -> r4 = 0, busy = 0.
  - The first write after release lands normally.
